// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg : shared defaults and helpers for the synchronous FIFO family
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int FIFO_DEF_WIDTH = 8;
  localparam int FIFO_DEF_DEPTH = 16;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ram.sv
// ============================================================================
// fifo_ram : simple dual-port register file, sync write / async read, no reset
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DEF_WIDTH,
  parameter int DEPTH      = FIFO_DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        we_i,
  input  logic [addr_w(DEPTH)-1:0]    waddr_i,
  input  logic [DATA_WIDTH-1:0]       wdata_i,
  input  logic [addr_w(DEPTH)-1:0]    raddr_i,
  output logic [DATA_WIDTH-1:0]       rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// ============================================================================
// sync_fifo_param : parametrised single-clock FIFO with FWFT option,
//                   almost flags, occupancy count and sticky error flags
// Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DEF_WIDTH,
  parameter int DEPTH      = FIFO_DEF_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_en,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     r_en,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [addr_w(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [PTR_W-1:0] c_AF_LVL = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] c_AE_LVL = PTR_W'(AE_LEVEL);
  localparam logic [PTR_W-1:0] c_ONE    = PTR_W'(1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of 2 and at least 2");
  end
  if ((AF_LEVEL < 0) || (AF_LEVEL > DEPTH)) begin : g_bad_af
    $error("sync_fifo_param: AF_LEVEL must lie within 0..DEPTH");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH)) begin : g_bad_ae
    $error("sync_fifo_param: AE_LEVEL must lie within 0..DEPTH");
  end

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Flags decode straight from the registered pointers: no extra latency.
  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                        (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign count        = wr_ptr_q - rd_ptr_q;
  assign almost_full  = (count >= c_AF_LVL);
  assign almost_empty = (count <= c_AE_LVL);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  assign w_wr_acc = w_en && !full;
  assign w_rd_acc = r_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_wr_acc) begin
      wr_ptr_d = wr_ptr_q + c_ONE;
    end
    if (w_rd_acc) begin
      rd_ptr_d = rd_ptr_q + c_ONE;
    end
    // A new error event outranks a clear in the same cycle.
    ovf_d = (w_en && full)  || (ovf_q && !clr_err);
    udf_d = (r_en && empty) || (udf_q && !clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (w_wr_acc),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (w_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    // Head word is forced to zero while empty so reset reads back as zero.
    assign data_out = empty ? '0 : w_rdata;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (w_rd_acc) begin
        dout_d = w_rdata;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
      end else begin
        dout_q <= dout_d;
      end
    end

    assign data_out = dout_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// ============================================================================
// tb_sync_fifo_param : directed self-checking bench, DEPTH=8 AF=6 AE=2
// Rev 1.0            : initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_param;

  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          w_en, r_en, clr_err;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0] count;

  logic          fw_w, fw_r;
  logic [DW-1:0] fw_din, fw_dout;
  logic          fw_full, fw_empty, fw_af, fw_ae, fw_ovf, fw_udf;
  logic [CW-1:0] fw_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)
  ) u_std (
    .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  sync_fifo_param #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .w_en(fw_w), .data_in(fw_din), .r_en(fw_r),
    .data_out(fw_dout), .full(fw_full), .empty(fw_empty),
    .almost_full(fw_af), .almost_empty(fw_ae), .count(fw_count),
    .overflow(fw_ovf), .underflow(fw_udf), .clr_err(1'b0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; w_en = 0; r_en = 0; clr_err = 0; data_in = '0;
    fw_w = 0; fw_r = 0; fw_din = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_aempty", 32'(almost_empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_afull", 32'(almost_full), 0);
    check("rst_dout", 32'(data_out), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_udf", 32'(underflow), 0);
    rst = 1'b0;
    tick();

    // Fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      w_en = 1; data_in = 8'(i);
      tick();
      check($sformatf("fill_count%0d", i), 32'(count), 32'(i));
      check($sformatf("fill_af%0d", i), 32'(almost_full), 32'(i >= 6));
      check($sformatf("fill_ae%0d", i), 32'(almost_empty), 32'(i <= 2));
      check($sformatf("fill_full%0d", i), 32'(full), 32'(i == 8));
    end
    w_en = 0;

    // Overflow attempt with 0xAA
    w_en = 1; data_in = 8'hAA;
    tick();
    w_en = 0;
    check("ovf_set", 32'(overflow), 1);
    check("ovf_count", 32'(count), 8);

    // Drain
    for (int i = 1; i <= 8; i++) begin
      r_en = 1;
      tick();
      check($sformatf("drain_dout%0d", i), 32'(data_out), 32'(i));
      check($sformatf("drain_count%0d", i), 32'(count), 32'(8 - i));
    end
    r_en = 0;
    check("drain_empty", 32'(empty), 1);

    // Underflow
    r_en = 1;
    tick();
    r_en = 0;
    check("udf_set", 32'(underflow), 1);
    check("udf_dout_hold", 32'(data_out), 8);
    check("ovf_sticky", 32'(overflow), 1);

    clr_err = 1;
    tick();
    clr_err = 0;
    check("clr_ovf", 32'(overflow), 0);
    check("clr_udf", 32'(underflow), 0);

    // Simultaneous read/write at count 4, across pointer wrap
    for (int i = 0; i < 4; i++) begin
      w_en = 1; data_in = 8'(8'h10 + i);
      tick();
    end
    check("sim_pre_count", 32'(count), 4);
    for (int k = 0; k < 20; k++) begin
      w_en = 1; r_en = 1; data_in = 8'(8'h14 + k);
      tick();
      check($sformatf("sim_dout%0d", k), 32'(data_out), 32'(8'h10 + k));
      check($sformatf("sim_count%0d", k), 32'(count), 4);
    end
    r_en = 0;
    for (int i = 0; i < 4; i++) begin
      w_en = 1; data_in = 8'(8'h28 + i);
      tick();
    end
    w_en = 0;
    check("sim_full", 32'(full), 1);

    // Read+write while full: write rejected
    w_en = 1; r_en = 1; data_in = 8'hEE;
    tick();
    w_en = 0; r_en = 0;
    check("fullrw_count", 32'(count), 7);
    check("fullrw_ovf", 32'(overflow), 1);
    check("fullrw_dout", 32'(data_out), 32'h24);
    for (int i = 0; i < 7; i++) begin
      logic [7:0] exp_v;
      exp_v = (i < 3) ? 8'(8'h25 + i) : 8'(8'h28 + i - 3);
      r_en = 1;
      tick();
      check($sformatf("fullrw_drain%0d", i), 32'(data_out), 32'(exp_v));
    end
    r_en = 0;
    check("fullrw_empty", 32'(empty), 1);

    // Async reset mid-operation: count 5, both error flags set
    r_en = 1;
    tick();
    r_en = 0;
    for (int i = 0; i < 5; i++) begin
      w_en = 1; data_in = 8'(8'h40 + i);
      tick();
    end
    w_en = 0;
    check("arst_pre_count", 32'(count), 5);
    check("arst_pre_udf", 32'(underflow), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_empty", 32'(empty), 1);
    check("arst_dout", 32'(data_out), 0);
    check("arst_ovf", 32'(overflow), 0);
    check("arst_udf", 32'(underflow), 0);
    tick();
    #2 rst = 1'b0;
    tick();
    w_en = 1; data_in = 8'h33;
    tick();
    w_en = 0; r_en = 1;
    tick();
    r_en = 0;
    check("arst_post_dout", 32'(data_out), 32'h33);
    check("arst_post_empty", 32'(empty), 1);

    // Thresholds on the way back down
    for (int i = 1; i <= 8; i++) begin
      w_en = 1; data_in = 8'(8'h80 + i);
      tick();
    end
    w_en = 0;
    for (int c = 7; c >= 0; c--) begin
      r_en = 1;
      tick();
      check($sformatf("dn_count%0d", c), 32'(count), 32'(c));
      check($sformatf("dn_af%0d", c), 32'(almost_full), 32'(c >= 6));
      check($sformatf("dn_ae%0d", c), 32'(almost_empty), 32'(c <= 2));
    end
    r_en = 0;

    // FWFT instance
    check("fw_init_empty", 32'(fw_empty), 1);
    fw_w = 1; fw_din = 8'h5C;
    tick();
    fw_w = 0;
    check("fw_empty_fall", 32'(fw_empty), 0);
    check("fw_head", 32'(fw_dout), 32'h5C);
    tick();
    check("fw_head_hold", 32'(fw_dout), 32'h5C);
    fw_r = 1;
    tick();
    fw_r = 0;
    check("fw_empty_rise", 32'(fw_empty), 1);
    check("fw_count0", 32'(fw_count), 0);
    fw_w = 1; fw_din = 8'hA1;
    tick();
    fw_din = 8'hB2;
    tick();
    fw_w = 0;
    check("fw_head2", 32'(fw_dout), 32'hA1);
    fw_r = 1;
    tick();
    fw_r = 0;
    check("fw_next", 32'(fw_dout), 32'hB2);
    check("fw_count1", 32'(fw_count), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO, the next generation of the team's basic synchronous FIFO.
- Adds configurable width and depth, a first-word-fall-through (FWFT) mode, programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags.
- Used as the general buffering block between producer and consumer stages in the same clock domain.

Parameters:
- DATA_WIDTH, 8: word width in bits.
- DEPTH, 16: number of entries; power of 2, minimum 2.
- AF_LEVEL, DEPTH-2: almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL.
- FWFT, 0: 0 = standard registered-read mode; 1 = first-word-fall-through mode.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- w_en  input  1  write request.
- data_in  input  DATA_WIDTH  write data.
- r_en  input  1  read request (pop).
- data_out  output  DATA_WIDTH  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was rejected.
- underflow  output  1  sticky: a read was rejected.
- clr_err  input  1  synchronous clear of overflow and underflow.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - Write and read pointers = 0, count = 0, data_out = 0, overflow = underflow = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - Memory contents are not reset.
- Reset mid-operation: stored data is discarded immediately. Flags reach their reset values asynchronously, without waiting for a clock edge.
- Pointers:
  - Width is $clog2(DEPTH)+1; the extra MSB is the wrap bit.
  - full: MSBs differ and lower bits are equal. empty: pointers are equal.
  - count = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
- Accepted write: w_en && !full. Data is stored at wr_ptr and wr_ptr increments on that edge.
- Accepted read: r_en && !empty. rd_ptr increments on that edge.
- Acceptance is evaluated independently per side:
  - Write while full is rejected even if a read occurs in the same cycle.
  - Read while empty is rejected even if a write occurs in the same cycle.
- Simultaneous accepted read and write: count is unchanged and both pointers advance.
- Wrap-around: pointers roll over from 2*DEPTH-1 to 0. The memory address is the lower ADDR_W bits.
- Standard mode (FWFT=0):
  - On an accepted read, data_out loads mem[rd_ptr] at that edge and is valid from the edge onward (1-cycle read latency).
  - data_out holds its value otherwise, including on a rejected read.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally.
  - The head word is valid whenever empty = 0, starting the cycle after the first accepted write.
  - r_en acknowledges and pops the head word. The next word appears after the edge.
  - When empty = 1, data_out is don't-care.
- Flag timing: full, empty, almost_full, almost_empty and count decode from the registered pointers. They update on the edge that changes the pointers, with no extra latency.
- Error flags:
  - overflow sets on the edge where w_en && full.
  - underflow sets on the edge where r_en && empty.
  - clr_err clears both flags on the next edge. If a set condition occurs in the same cycle as clr_err, the set wins.
- Parameter check: elaboration-time error if DEPTH is not a power of 2, or if AF_LEVEL or AE_LEVEL lies outside 0..DEPTH.

Decomposition:
- Shared package fifo_pkg:
  - Default constants FIFO_DEF_WIDTH = 8 and FIFO_DEF_DEPTH = 16.
  - Function addr_w(depth) returning the $clog2 result.
- Sub-module fifo_ram:
  - Simple dual-port register file: DATA_WIDTH x DEPTH, synchronous write, asynchronous read, no reset.
  - sync_fifo_param holds the pointers, flags, count, output register and error logic.

Test Plan (DEPTH=8, AF_LEVEL=6, AE_LEVEL=2):
- Fill and drain, FWFT=0:
  - Write 0x01..0x08 on 8 consecutive edges -> full = 1, count = 8, almost_full asserted from count = 6.
  - Then read 8 times -> data_out shows 0x01..0x08, each one edge after its r_en. Finally empty = 1 and count = 0.
- Overflow and underflow:
  - With the FIFO full, pulse w_en with 0xAA -> overflow = 1, count stays 8, 0xAA is never read out.
  - With the FIFO empty, pulse r_en -> underflow = 1 and data_out is unchanged.
  - clr_err -> both flags return to 0.
- Simultaneous read and write:
  - With count = 4, drive w_en and r_en together for 20 cycles with incrementing data -> count stays 4 and output order is preserved across pointer wrap.
  - With count = 8 (full), w_en+r_en -> write rejected, count becomes 7, overflow = 1.
- FWFT=1:
  - Write 0x5C into an empty FIFO -> empty falls and data_out = 0x5C after that edge, with no r_en.
  - Pulse r_en -> empty rises.
- Async reset mid-operation:
  - With count = 5, assert rst between clock edges -> immediately count = 0, empty = 1, data_out = 0, error flags = 0.
  - After release, writing 0x33 then reading returns 0x33.
- Thresholds:
  - Step count 0 -> 8 -> 0 -> almost_empty high exactly for count <= 2, almost_full high exactly for count >= 6.
